rv32_inst_encoder: RTL
======================

Name: rv32_inst_encoder

Overview:
- Converts internal instruction codes (8-bit e_instruction: [7:6]=00, [5:3]=inst type, [2:0]=ALU sel/funct3) plus operand fields into 32-bit RV32I machine words. This is the reverse of the decode path.
- Output words are buffered in a small FIFO and streamed to the fetch/injection port over a valid/ready handshake.
- Used by the debug instruction injector and the boot sequencer.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- ERR_CNT_W, 8, width of the saturating illegal-request counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- flush  in  1  synchronous clear of the FIFO contents.
- req_valid  in  1  request present.
- req_ready  out  1  encoder can accept a request.
- req_op  in  8  e_instruction code.
- req_rd  in  5  destination register.
- req_rs1  in  5  source register 1.
- req_rs2  in  5  source register 2; used by R types only.
- req_imm  in  12  immediate; shifts use [4:0] only.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer takes the head.
- out_inst  out  32  encoded instruction at the FIFO head.
- err  out  1  one-cycle pulse: illegal op was accepted and dropped.
- err_cnt  out  ERR_CNT_W  saturating count of illegal requests.
- count  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async, rst=1):
  - count=0, out_valid=0, out_inst=0, err=0, err_cnt=0.
  - Read and write pointers = 0.
  - req_ready=1 once rst deasserts.
- Handshakes:
  - Accept when req_valid && req_ready.
  - Pop when out_valid && out_ready.
  - req_ready = (count < DEPTH). It is not combinationally dependent on out_ready.
- Legal op codes (19 total):
  - Type 000 (R1), any funct3.
  - Type 001 (R2), funct3 000 or 101 only.
  - Type 010 (I1), any funct3.
  - Type 011 (I2), funct3 101 only.
  - Bits [7:6] must be 00.
  - Every other code is illegal.
- Encoding, with f3 = req_op[2:0]:
  - R1: {7'b0000000, rs2, rs1, f3, rd, 7'b0110011}.
  - R2: {7'b0100000, rs2, rs1, f3, rd, 7'b0110011}.
  - I1, f3 not 001/101: {req_imm, rs1, f3, rd, 7'b0010011}. The immediate is passed as-is; sign interpretation belongs downstream.
  - I1, f3=001 (SLLI) or f3=101 (SRLI): {7'b0000000, req_imm[4:0], rs1, f3, rd, 7'b0010011}.
  - I2 (SRAI): {7'b0100000, req_imm[4:0], rs1, 3'b101, rd, 7'b0010011}.
  - For shifts, req_imm[11:5] is ignored.
- Latency: a word accepted in cycle N is visible at out_inst/out_valid in cycle N+1 when the FIFO was empty. out_inst comes from registered FIFO storage.
- Ordering: strict FIFO.
- Simultaneous push and pop: count is unchanged, both pointers advance.
  - When full, a pop does not raise req_ready in the same cycle; it rises the next cycle.
  - When empty, no pop is possible, so push and pop never coincide on the same entry.
- Illegal request:
  - The handshake completes (req_ready honoured) and nothing is written.
  - err=1 in cycle N+1.
  - err_cnt increments and saturates at all-ones.
- Pointer wrap: pointers wrap modulo DEPTH. Full/empty is derived from count.
- flush:
  - Takes priority over push and pop in the same cycle.
  - count=0, pointers=0, out_valid=0 next cycle.
  - A request accepted in the flush cycle is discarded.
  - err_cnt is not affected.
- Reset mid-stream: all entries are lost immediately; outputs take reset values asynchronously.

Test Plan:
- Reset, then ADD (req_op=0x00) with rd=3, rs1=1, rs2=2 -> out_inst=0x002081B3, out_valid=1 one cycle after accept.
- SUB (0x08) rd=5, rs1=6, rs2=7 -> 0x407302B3. NOP as ADDI (0x10) with all fields 0 -> 0x00000013.
- SRAI (0x1D) rd=1, rs1=2, imm=0xFE3 -> 0x40315093 (upper immediate forced). ADDI rd=1, rs1=0, imm=0xFFF -> 0xFFF00093.
- req_op=0x09 (R2, funct3 001), then 0x40 -> both accepted, no output, two err pulses, err_cnt=2. Drive 300 illegal requests -> err_cnt holds 0xFF.
- Hold out_ready=0 and push 5 requests:
  - 4 are accepted, count=4, req_ready=0 on the fifth.
  - Assert out_ready -> words drain in order; req_ready returns the cycle after the first pop.
  - Sustained push and pop at full rate for 20 cycles -> no loss, no duplication.
- With count=3, assert flush together with a valid request -> next cycle count=0, out_valid=0, and the request is not emitted. Assert rst mid-drain -> outputs return to reset values asynchronously.

Source files
------------

// File: rtl/rv32_inst_encoder.sv
// rv32_inst_encoder
//   Turns internal e_instruction codes plus operand fields into 32-bit RV32I
//   machine words. Words are buffered in a small FIFO and streamed out over a
//   valid/ready handshake. This is the encode-side mirror of the decode path,
//   used by the debug instruction injector and the boot sequencer.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   flush              synchronous clear of the FIFO (wins over push/pop)
//   req_valid/ready    request handshake; req_ready = FIFO not full
//   req_op             e_instruction: [7:6]=00, [5:3]=type, [2:0]=funct3
//   req_rd/rs1/rs2     register fields (rs2 used by R types only)
//   req_imm            12-bit immediate (shifts use [4:0])
//   out_valid/ready    output handshake on the FIFO head
//   out_inst           encoded word at the FIFO head (0 when empty)
//   err                one-cycle pulse after an illegal op was accepted
//   err_cnt            saturating count of illegal requests
//   count              current FIFO occupancy
`default_nettype none

module rv32_inst_encoder #(
  parameter int DEPTH     = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [7:0]              req_op,
  input  logic [4:0]              req_rd,
  input  logic [4:0]              req_rs1,
  input  logic [4:0]              req_rs2,
  input  logic [11:0]             req_imm,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_inst,
  output logic                    err,
  output logic [ERR_CNT_W-1:0]    err_cnt,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = DEPTH[PTR_W:0];

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  typedef enum logic [2:0] {
    TYPE_R1 = 3'b000,
    TYPE_R2 = 3'b001,
    TYPE_I1 = 3'b010,
    TYPE_I2 = 3'b011
  } inst_type_e;

  inst_type_e        op_type;
  logic [2:0]        f3;
  logic              op_legal;
  logic [31:0]       enc_word;

  logic [31:0]       mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  logic              accept;
  logic              illegal_take;
  logic              push;
  logic              pop;

  // Legality check and word assembly. Shift forms take only imm[4:0] and
  // force the upper seven bits to the funct7 pattern, so a caller can pass
  // a sign-extended shift amount without corrupting the word.
  always_comb begin
    op_type  = inst_type_e'(req_op[5:3]);
    f3       = req_op[2:0];
    op_legal = 1'b0;
    enc_word = '0;
    if (req_op[7:6] == 2'b00) begin
      case (op_type)
        TYPE_R1: begin
          op_legal = 1'b1;
          enc_word = {7'b0000000, req_rs2, req_rs1, f3, req_rd, OPC_OP};
        end
        TYPE_R2: begin
          op_legal = (f3 == 3'b000) || (f3 == 3'b101);
          enc_word = {7'b0100000, req_rs2, req_rs1, f3, req_rd, OPC_OP};
        end
        TYPE_I1: begin
          op_legal = 1'b1;
          if ((f3 == 3'b001) || (f3 == 3'b101))
            enc_word = {7'b0000000, req_imm[4:0], req_rs1, f3, req_rd, OPC_OP_IMM};
          else
            enc_word = {req_imm, req_rs1, f3, req_rd, OPC_OP_IMM};
        end
        TYPE_I2: begin
          op_legal = (f3 == 3'b101);
          enc_word = {7'b0100000, req_imm[4:0], req_rs1, 3'b101, req_rd, OPC_OP_IMM};
        end
        default: begin
          op_legal = 1'b0;
          enc_word = '0;
        end
      endcase
    end
  end

  // Handshake qualifiers. req_ready looks only at the registered count, so a
  // pop from a full FIFO frees a slot one cycle later, never combinationally.
  assign req_ready    = (count < FULL_COUNT);
  assign out_valid    = (count != '0);
  assign accept       = req_valid && req_ready;
  assign illegal_take = accept && !op_legal;
  assign push         = accept && op_legal && !flush;
  assign pop          = out_valid && out_ready && !flush;
  assign out_inst     = out_valid ? mem[rd_ptr] : '0;

  // Pointer and occupancy bookkeeping. Pointers wrap naturally because DEPTH
  // is a power of two; full/empty come from count alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array. No reset needed: out_inst is masked while the FIFO is
  // empty, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= enc_word;
  end

  // Illegal-request reporting. The request is still handshaked so the
  // producer never stalls on a bad code; it just leaves a pulse and a tally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      err <= illegal_take;
      if (illegal_take && (err_cnt != '1))
        err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire
